// File: rtl/gyrator_synth_inductor_mc.sv
// gyrator_synth_inductor_mc: multi-channel discrete-time synthetic inductor.
// Each accepted sample v on channel c updates i[c] += (v*k) >>> KSHIFT, clamped to +/-LIMIT.
// Two-stage pipeline: stage 1 registers the product, stage 2 does the accumulator
// read-modify-write and registers the result.
// Optional feature macro: GYR_LEAK_EN (adds acc >>> LEAK_SHIFT leak term, lossy inductor).
// Ports:
//   clk, rst_n          clock, async active-low reset
//   clr                 sync clear of accumulators and in-flight data
//   in_valid/in_ready   input handshake; in_ch, in_v, k_coef sampled on transfer
//   out_valid/out_ready output handshake; out_ch, out_i (acc[AW-1:AW-DW]), out_sat
module gyrator_synth_inductor_mc #(
  parameter int unsigned   CHANNELS   = 4,
  parameter int unsigned   CW         = 2,
  parameter int unsigned   DW         = 16,
  parameter int unsigned   KW         = 8,
  parameter int unsigned   KSHIFT     = 4,
  parameter int unsigned   AW         = 24,
  parameter logic [AW-1:0] LIMIT      = {1'b0, {(AW-1){1'b1}}},
  parameter int unsigned   LEAK_SHIFT = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CW-1:0]        in_ch,
  input  logic signed [DW-1:0] in_v,
  input  logic [KW-1:0]        k_coef,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_ch,
  output logic signed [DW-1:0] out_i,
  output logic                 out_sat
);

  localparam int unsigned PW = DW + KW;  // product width
  localparam int unsigned SW = AW + 1;   // sum width, one guard bit

  localparam logic signed [SW-1:0] LimPos = {1'b0, LIMIT};
  localparam logic signed [SW-1:0] LimNeg = -LimPos;

  // Stage 1 registers
  logic                 s1_valid_q;
  logic [CW-1:0]        s1_ch_q;
  logic signed [PW-1:0] s1_p_q;

  // Stage 2 / output registers
  logic                 out_valid_q;
  logic [CW-1:0]        out_ch_q;
  logic signed [DW-1:0] out_i_q;
  logic                 out_sat_q;

  logic signed [AW-1:0] acc_q [CHANNELS];

  logic                 advance;
  logic                 in_xfer;
  logic                 in_ch_ok;
  logic signed [PW:0]   prod_full;
  logic                 s2_we;
  logic signed [AW-1:0] acc_cur;
  logic signed [SW-1:0] acc_ext;
  logic signed [SW-1:0] scaled;
  logic signed [SW-1:0] sum;
  logic                 sat_hi;
  logic                 sat_lo;
  logic signed [AW-1:0] acc_new;

  // The whole pipeline freezes only when a result is waiting on downstream.
  assign advance  = !(out_valid_q && !out_ready);
  assign in_ready = advance && !clr;
  assign in_xfer  = in_valid && in_ready;
  // Out-of-range channels are accepted but never enter stage 1 as valid.
  assign in_ch_ok = (32'(in_ch) < CHANNELS);

  // Zero-extend k so the multiply stays signed; the result fits in PW bits.
  assign prod_full = in_v * $signed({1'b0, k_coef});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_ch_q    <= '0;
      s1_p_q     <= '0;
    end else if (clr) begin
      s1_valid_q <= 1'b0;
    end else if (advance) begin
      s1_valid_q <= in_xfer && in_ch_ok;
      if (in_xfer) begin
        s1_ch_q <= in_ch;
        s1_p_q  <= prod_full[PW-1:0];
      end
    end
  end

  always_comb begin
    acc_cur = acc_q[s1_ch_q];
    acc_ext = {acc_cur[AW-1], acc_cur};
    // Arithmetic shift by bit selection, then sign-extend to SW bits.
    scaled  = {{(SW-PW+KSHIFT){s1_p_q[PW-1]}}, s1_p_q[PW-1:KSHIFT]};
`ifdef GYR_LEAK_EN
    sum = acc_ext - {{(LEAK_SHIFT+1){acc_cur[AW-1]}}, acc_cur[AW-1:LEAK_SHIFT]} + scaled;
`else
    sum = acc_ext + scaled;
`endif
    sat_hi = (sum > LimPos);
    sat_lo = (sum < LimNeg);
    if (sat_hi) begin
      acc_new = LimPos[AW-1:0];
    end else if (sat_lo) begin
      acc_new = LimNeg[AW-1:0];
    end else begin
      acc_new = sum[AW-1:0];
    end
  end

  assign s2_we = advance && s1_valid_q && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < int'(CHANNELS); c++) acc_q[c] <= '0;
    end else if (clr) begin
      for (int c = 0; c < int'(CHANNELS); c++) acc_q[c] <= '0;
    end else if (s2_we) begin
      acc_q[s1_ch_q] <= acc_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_i_q     <= '0;
      out_sat_q   <= 1'b0;
    end else if (clr) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_i_q     <= '0;
      out_sat_q   <= 1'b0;
    end else if (advance) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_ch_q  <= s1_ch_q;
        out_i_q   <= acc_new[AW-1:AW-DW];
        out_sat_q <= sat_hi || sat_lo;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_i     = out_i_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_gyrator_synth_inductor_mc.sv
// Self-checking bench for gyrator_synth_inductor_mc (default parameters, leak disabled).
module tb_gyrator_synth_inductor_mc;

  logic               clk;
  logic               rst_n;
  logic               clr;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_ch;
  logic signed [15:0] in_v;
  logic [7:0]         k_coef;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_ch;
  logic signed [15:0] out_i;
  logic               out_sat;

  gyrator_synth_inductor_mc dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ch    (in_ch),
    .in_v     (in_v),
    .k_coef   (k_coef),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch   (out_ch),
    .out_i    (out_i),
    .out_sat  (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]         ch;
    logic signed [15:0] v;
    logic [7:0]         k;
    logic signed [15:0] ei;
    logic               es;
  } vec_t;

  typedef struct {
    logic [1:0]         ch;
    logic signed [15:0] i;
    logic               sat;
  } exp_t;

  vec_t vecs[$];
  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic [1:0] ch, input int v, input int k, input int ei,
                              input logic es);
    vec_t r;
    r.ch = ch;
    r.v  = 16'(v);
    r.k  = 8'(k);
    r.ei = 16'(ei);
    r.es = es;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one sample, wait (bounded) for acceptance, optionally record its expected result.
  task automatic send(input logic [1:0] ch, input int v, input int k, input int ei,
                      input logic es, input logic push);
    int   guard;
    logic ok;
    exp_t e;
    guard    = 0;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_ch    = ch;
    in_v     = 16'(v);
    k_coef   = 8'(k);
    while (!ok && guard < 100) begin
      @(negedge clk);
      ok = in_ready;
      guard++;
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
    end else begin
      @(posedge clk);
      if (push) begin
        e.ch  = ch;
        e.i   = 16'(ei);
        e.sat = es;
        expq.push_back(e);
      end
    end
    #1 in_valid = 1'b0;
  endtask

  // Scoreboard: every output transfer must match the next expected result in order.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out: got ch=%0d i=%0d sat=%0d, expected no output",
                 out_ch, out_i, out_sat);
      end else begin
        e = expq.pop_front();
        if (out_ch !== e.ch || out_i !== e.i || out_sat !== e.sat) begin
          bad++;
          $display("FAIL out_data: got ch=%0d i=%0d sat=%0d expected ch=%0d i=%0d sat=%0d",
                   out_ch, out_i, out_sat, e.ch, e.i, e.sat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [15:0] held;

    // Ramp continuation after the latency-checked first sample.
    for (int n = 2; n <= 8; n++) vecs.push_back(mk(2'd0, 256, 16, n, 1'b0));
    // Saturation: each step adds 32767*255>>>4 = 522224.
    for (int n = 1; n <= 16; n++) vecs.push_back(mk(2'd1, 32767, 255, (n * 522224) >>> 8, 1'b0));
    vecs.push_back(mk(2'd1, 32767, 255, 32767, 1'b1));
    // 8388607 + floor(-8355585/16) = 8388607 - 522225 = 7866382 -> >>8 = 30728
    vecs.push_back(mk(2'd1, -32767, 255, 30728, 1'b0));
    // Channel isolation, interleaved.
    for (int n = 1; n <= 4; n++) begin
      vecs.push_back(mk(2'd2, -256, 16, -n, 1'b0));
      vecs.push_back(mk(2'd3, 512, 16, 2 * n, 1'b0));
    end

    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_ch     = '0;
    in_v      = '0;
    k_coef    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_i", int'(out_i), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    @(posedge clk);
    #1;

    // Latency: out_valid exactly two cycles after accept.
    send(2'd0, 256, 16, 1, 1'b0, 1'b1);
    @(negedge clk);
    chk("lat_cycle1_valid", int'(out_valid), 0);
    @(negedge clk);
    chk("lat_cycle2_valid", int'(out_valid), 1);
    @(posedge clk);
    #1;

    // Streamed table at full throughput.
    foreach (vecs[j]) send(vecs[j].ch, int'(vecs[j].v), int'(vecs[j].k), int'(vecs[j].ei),
                           vecs[j].es, 1'b1);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure mid-stream: ch0 continues from 8 to 14.
    fork
      begin
        for (int n = 9; n <= 14; n++) send(2'd0, 256, 16, n, 1'b0, 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_ready0", int'(in_ready), 0);
        held = out_i;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          chk("stall_ready", int'(in_ready), 0);
          chk("stall_hold_i", int'(out_i), int'(held));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // clr with one sample in stage 1 and another presented alongside clr.
    send(2'd0, 256, 16, 0, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_ch    = 2'd0;
    in_v     = 16'sd256;
    k_coef   = 8'd16;
    clr      = 1'b1;
    @(negedge clk);
    chk("clr_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("clr_no_valid", int'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    send(2'd1, 0, 0, 0, 1'b0, 1'b1);   // ch1 was saturated; clr must have zeroed it
    send(2'd0, 256, 16, 1, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;

    // Asynchronous reset with a sample in flight.
    send(2'd0, 256, 16, 0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_i", int'(out_i), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", int'(in_ready), 1);
    chk("arst_no_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    send(2'd0, 256, 16, 1, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
